// File: rtl/counter_ctrl_pkg.sv
// Shared types for the counter sequencer: FSM states, job record, default widths.
// COUNTER_CTRL_ABORT_EN (optional, see counter_ctrl) does not change anything here.
package counter_ctrl_pkg;

  localparam int CC_WIDTH    = 4;
  localparam int CC_STEP_W   = 4;
  localparam int CC_MAX_NREQ = 8;
  localparam int CC_ID_W     = $clog2(CC_MAX_NREQ);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    RUN  = 2'd2,
    RESP = 2'd3
  } state_t;

  // The id field is sized for the largest supported requester count.
  typedef struct packed {
    logic [CC_WIDTH-1:0]  start;
    logic                 up;
    logic [CC_STEP_W-1:0] steps;
    logic [CC_ID_W-1:0]   id;
  } job_t;

  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/counter_ctrl_if.sv
// Job request / response bundle between requesters (master) and counter_ctrl (slave).
// Requests: per-requester valid/ready; response: single valid/ready channel with owner id.
interface counter_ctrl_if
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = CC_WIDTH,
  parameter int STEP_W = CC_STEP_W,
  parameter int NREQ   = 2
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]        req_valid;
  logic [NREQ-1:0]        req_ready;
  logic [NREQ*WIDTH-1:0]  req_start;
  logic [NREQ-1:0]        req_up;
  logic [NREQ*STEP_W-1:0] req_steps;

  logic                   rsp_valid;
  logic                   rsp_ready;
  logic [WIDTH-1:0]       rsp_data;
  logic [IDW-1:0]         rsp_id;

  modport master (
    output req_valid, req_start, req_up, req_steps, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_id
  );

  modport slave (
    input  req_valid, req_start, req_up, req_steps, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_id
  );

endinterface

// File: rtl/counter_ctrl_rr_arb.sv
// Round-robin arbiter: combinational one-hot grant from req, search starts after the last winner.
// Pointer moves only when the parent reports the grant was accepted; reset gives requester 0 priority.
module counter_ctrl_rr_arb
  import counter_ctrl_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req,
  input  logic            accept,
  output logic [NREQ-1:0] gnt
);
  localparam int IDW = $clog2(NREQ);

  logic [IDW-1:0] ptr_q;
  logic [IDW-1:0] gnt_idx;
  logic           found;

  always_comb begin
    int k;
    gnt     = '0;
    gnt_idx = ptr_q;
    found   = 1'b0;
    k       = 0;
    for (int i = 0; i < NREQ; i++) begin
      k = int'(ptr_q) + i;
      if (k >= NREQ) begin
        k = k - NREQ;
      end
      if (!found && req[k]) begin
        found   = 1'b1;
        gnt_idx = IDW'(k);
      end
    end
    if (found) begin
      gnt[gnt_idx] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ptr_q <= '0;
    end else if (accept && found) begin
      ptr_q <= IDW'(wrap_inc(int'(gnt_idx), NREQ));
    end
  end

endmodule

// File: rtl/counter_ctrl.sv
// Sequences jobs onto an external loadable up/down counter: load, step N cycles, hold, report.
// Latency steps+2 cycles from accept to rsp_valid; optional COUNTER_CTRL_ABORT_EN cuts RUN short.
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int WIDTH  = CC_WIDTH,
  parameter int STEP_W = CC_STEP_W,
  parameter int NREQ   = 2
) (
  input  logic             clk,
  input  logic             rst,
  counter_ctrl_if.slave    bus,
  output logic             cnt_load,
  output logic             cnt_updown,
  output logic [WIDTH-1:0] cnt_data,
  input  logic [WIDTH-1:0] cnt_q
`ifdef COUNTER_CTRL_ABORT_EN
  ,
  input  logic             abort,
  output logic             rsp_aborted
`endif
);
  localparam int IDW = $clog2(NREQ);

  state_t            state_q, state_d;
  job_t              job_q, job_in;
  logic [STEP_W-1:0] steps_left_q;
  logic [NREQ-1:0]   gnt;
  logic              idle;
  logic              accept;
  logic              run_abort;

  // Requests are only visible while idle and out of reset.
  assign idle   = (state_q == IDLE) && !rst;
  assign accept = idle && (|gnt);

  counter_ctrl_rr_arb #(
    .NREQ (NREQ)
  ) u_arb (
    .clk    (clk),
    .rst    (rst),
    .req    (bus.req_valid),
    .accept (accept),
    .gnt    (gnt)
  );

  assign bus.req_ready = idle ? gnt : '0;

  always_comb begin
    job_in = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt[i]) begin
        job_in.start = CC_WIDTH'(bus.req_start[i*WIDTH +: WIDTH]);
        job_in.up    = bus.req_up[i];
        job_in.steps = CC_STEP_W'(bus.req_steps[i*STEP_W +: STEP_W]);
        job_in.id    = CC_ID_W'(i);
      end
    end
  end

`ifdef COUNTER_CTRL_ABORT_EN
  assign run_abort = abort;
`else
  assign run_abort = 1'b0;
`endif

  // The counter has no enable, so every non-RUN state reloads it with its own value.
  always_comb begin
    state_d       = state_q;
    cnt_load      = 1'b1;
    cnt_updown    = 1'b0;
    cnt_data      = cnt_q;
    bus.rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        cnt_data = WIDTH'(job_q.start);
        state_d  = (job_q.steps != '0) ? RUN : RESP;
      end
      RUN: begin
        cnt_load   = 1'b0;
        cnt_updown = job_q.up;
        if (run_abort || (steps_left_q == STEP_W'(1))) begin
          state_d = RESP;
        end
      end
      RESP: begin
        bus.rsp_valid = 1'b1;
        if (bus.rsp_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign bus.rsp_data = cnt_q;
  assign bus.rsp_id   = IDW'(job_q.id);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      job_q        <= '0;
      steps_left_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        job_q        <= job_in;
        steps_left_q <= STEP_W'(job_in.steps);
      end else if (state_q == RUN) begin
        steps_left_q <= steps_left_q - STEP_W'(1);
      end
    end
  end

`ifdef COUNTER_CTRL_ABORT_EN
  logic aborted_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      aborted_q <= 1'b0;
    end else if (accept) begin
      aborted_q <= 1'b0;
    end else if ((state_q == RUN) && abort) begin
      aborted_q <= 1'b1;
    end
  end

  assign rsp_aborted = aborted_q;
`endif

endmodule

// File: doc/counter_ctrl.md
# counter_ctrl

Sequencer and arbiter for the 4-bit loadable up/down counter.
- Accepts count jobs from NREQ requesters; each job is a start value, a direction and a step count.
- Grants one requester at a time, round-robin.
- Drives the counter's load/updown/data pins so the counter loads the start value, steps the requested number of cycles, then freezes.
- Returns the final value on a valid/ready response channel.

## Interface
Parameters:
- WIDTH, 4: counter data width; must match the counter instance.
- STEP_W, 4: step-count width (0..2^STEP_W-1 steps).
- NREQ, 2: number of requesters (2..8).

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  reset, synchronous, active-high; tie to the counter's rst.
- req_valid  in  NREQ  per-requester job valid.
- req_ready  out  NREQ  per-requester job accept; depends combinationally on req_valid.
- req_start  in  NREQ*WIDTH  start value; slice i belongs to requester i.
- req_up  in  NREQ  direction: 1 = up, 0 = down.
- req_steps  in  NREQ*STEP_W  number of count cycles.
- rsp_valid  out  1  final value available.
- rsp_ready  in  1  response consumer accept.
- rsp_data  out  WIDTH  final counter value.
- rsp_id  out  $clog2(NREQ)  requester that owns the response.
- cnt_load  out  1  to counter load.
- cnt_updown  out  1  to counter updown.
- cnt_data  out  WIDTH  to counter data.
- cnt_q  in  WIDTH  from counter data_out.

## Operation
- The counter has no enable and changes every cycle it is not loaded. To hold it, the controller asserts cnt_load=1 with cnt_data=cnt_q.
- States are IDLE, LOAD, RUN and RESP.
  - IDLE: hold the counter. The arbiter picks one valid requester; req_ready=1 only on the granted bit.
    - On handshake, capture start, up, steps and id, then go to LOAD.
  - LOAD: cnt_load=1, cnt_data=captured start.
    - Go to RUN if steps!=0, else go to RESP.
  - RUN: cnt_load=0, cnt_updown=captured up. A step counter is preloaded with steps and decrements once per RUN cycle.
    - When the step counter reaches 1, go to RESP.
  - RESP: hold the counter. rsp_valid=1, rsp_data=cnt_q, rsp_id=captured id.
    - On rsp_ready, go to IDLE.
- Arithmetic wraps modulo 2^WIDTH, as in the counter: start 4'hE, up, 3 steps gives 4'h1.
- Round-robin arbitration:
  - The grant search starts at the index after the last granted requester.
  - The pointer advances only on an accepted job.
  - After reset, requester 0 has highest priority.
- The first IDLE cycle after accepting a job cannot accept another one (the state is no longer IDLE). Maximum throughput is one job per steps+3 cycles.
- Reset mid-job:
  - The FSM returns to IDLE, rsp_valid drops, and the pointer is cleared.
  - The counter resets to 0 via the shared rst. The job is lost and is not reported.
- A requester may drop req_valid before grant. Inputs are not sampled outside the IDLE handshake.

## Timing
- Reset values:
  - Outputs: req_ready=0 while rst is high; rsp_valid=0, rsp_data=cnt_q (0), rsp_id=0, cnt_load=1, cnt_data=cnt_q, cnt_updown=0.
  - Internal state: state=IDLE, pointer=0.
- All outputs are combinational from registered state plus cnt_q; req_ready additionally depends on req_valid.
- Job accepted at edge T (cycle T-1 handshake):
  - LOAD occupies cycle T.
  - Counter equals start after edge T+1.
  - RUN occupies cycles T+1..T+steps.
  - rsp_valid rises in cycle T+steps+1.
- steps=0: rsp_valid rises in cycle T+1 with rsp_data=start.
- rsp_valid, rsp_data and rsp_id stay stable until rsp_ready is sampled high.

## Configuration
- COUNTER_CTRL_ABORT_EN defined:
  - Adds input abort (1 bit) and output rsp_aborted (1 bit).
  - abort=1 in RUN leaves RUN at the next edge and enters RESP with rsp_aborted=1 and rsp_data equal to the partial count.
  - abort is ignored in all other states.
  - rsp_aborted is 0 for normally completed jobs and after reset.
- Not defined: neither port exists and every job runs to completion.

## Structure
- counter_ctrl_pkg holds:
  - the state enum typedef (IDLE, LOAD, RUN, RESP);
  - default WIDTH and STEP_W localparams;
  - a job struct typedef {start, up, steps, id}.
- Sub-module counter_ctrl_rr_arb contains the parameterised NREQ round-robin arbiter: request vector in, one-hot grant out, pointer update on accept.
- The counter itself is instantiated by the parent, not inside counter_ctrl.

## Test plan
- Reset and idle: rst held 3 cycles, then released with no requests -> cnt_load=1, cnt_q stays 0, rsp_valid=0, req_ready=0.
- Single job: req 0 with start=3, up=1, steps=4 -> rsp_valid in cycle T+5, rsp_data=7, rsp_id=0; counter stays 7 while rsp_ready is held low for 3 cycles.
- Wrap and zero steps:
  - start=1, down, 3 steps -> rsp_data=4'hE.
  - start=9, steps=0 -> rsp_data=9 one cycle after LOAD.
- Arbitration: both requesters valid continuously, four jobs -> grants alternate 0,1,0,1; rsp_id matches each job.
- Reset mid-RUN: rst asserted in the second RUN cycle -> next cycle is IDLE, rsp_valid=0, cnt_q=0, next grant goes to requester 0.
- Abort (COUNTER_CTRL_ABORT_EN): start=0, up, 10 steps, abort in the third RUN cycle -> rsp_aborted=1, rsp_data=3.
